// File: rtl/wb_write_queue.sv
// Register-bank write queue: strict FIFO of (dest, data) pairs drained one per cycle.
// Define WBQ_BYPASS_EN to build the sr1/sr2 lookup of pending entries (youngest match wins).
module wb_write_queue #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    input  logic [4:0]               in_dest,
    input  logic [31:0]              in_data,
    output logic                     in_ready,
    input  logic                     drain_hold,
    output logic                     rf_write,
    output logic [4:0]               rf_wr,
    output logic [31:0]              rf_writereg,
    input  logic [4:0]               sr1,
    input  logic [4:0]               sr2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [31:0]              byp1,
    output logic [31:0]              byp2,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [4:0]    dest_q [DEPTH];
    logic [31:0]   data_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          push, pop, empty;

    assign empty       = (level_q == '0);
    assign in_ready    = (level_q < LW'(DEPTH));
    assign rf_write    = !empty && !drain_hold;
    assign rf_wr       = empty ? 5'd0  : dest_q[rd_ptr_q];
    assign rf_writereg = empty ? 32'd0 : data_q[rd_ptr_q];
    assign level       = level_q;

    assign push = in_valid && in_ready;
    assign pop  = rf_write;

    // Pointer and occupancy next state; power-of-two depth makes the pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Entry storage needs no reset: occupancy alone defines which slots are live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            dest_q[wr_ptr_q] <= in_dest;
            data_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef WBQ_BYPASS_EN
    // Scan oldest to newest so the youngest matching entry overrides older ones.
    always_comb begin
        logic [AW-1:0] idx;
        hit1 = 1'b0;
        hit2 = 1'b0;
        byp1 = 32'd0;
        byp2 = 32'd0;
        idx  = '0;
        for (int k = 0; k < int'(DEPTH); k++) begin
            idx = rd_ptr_q + AW'(k);
            if (LW'(k) < level_q) begin
                if (dest_q[idx] == sr1) begin
                    hit1 = 1'b1;
                    byp1 = data_q[idx];
                end
                if (dest_q[idx] == sr2) begin
                    hit2 = 1'b1;
                    byp2 = data_q[idx];
                end
            end
        end
    end
`else
    logic unused_sr;
    assign unused_sr = ^{sr1, sr2};
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
    assign byp1 = 32'd0;
    assign byp2 = 32'd0;
`endif

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed, table-driven bench for wb_write_queue (DEPTH = 4); lookup expectations follow WBQ_BYPASS_EN.
module tb_wb_write_queue;

`ifdef WBQ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, drain_hold;
    logic [4:0]  in_dest, sr1, sr2;
    logic [31:0] in_data;
    logic        in_ready, rf_write, hit1, hit2;
    logic [4:0]  rf_wr;
    logic [31:0] rf_writereg, byp1, byp2;
    logic [2:0]  level;

    int checks = 0;
    int passed = 0;

    wb_write_queue #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_dest(in_dest), .in_data(in_data),
        .in_ready(in_ready), .drain_hold(drain_hold), .rf_write(rf_write), .rf_wr(rf_wr),
        .rf_writereg(rf_writereg), .sr1(sr1), .sr2(sr2), .hit1(hit1), .hit2(hit2),
        .byp1(byp1), .byp2(byp2), .level(level)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, v, hold;
        logic [4:0]  d, s1, s2;
        logic [31:0] dat;
        int          lvl;
        bit          rdy, wr, h1, h2;
        logic [4:0]  ewr;
        logic [31:0] edat, b1, b2;
    } vec_t;

    function automatic vec_t mk(bit rst, bit v, logic [4:0] d, logic [31:0] dat, bit hold,
                                logic [4:0] s1, logic [4:0] s2, int lvl, bit rdy, bit wr,
                                logic [4:0] ewr, logic [31:0] edat, bit h1, logic [31:0] b1,
                                bit h2, logic [31:0] b2);
        vec_t t;
        t.rst = rst; t.v = v; t.d = d; t.dat = dat; t.hold = hold; t.s1 = s1; t.s2 = s2;
        t.lvl = lvl; t.rdy = rdy; t.wr = wr; t.ewr = ewr; t.edat = edat;
        t.h1 = h1 & BYP; t.b1 = BYP ? b1 : 32'd0;
        t.h2 = h2 & BYP; t.b2 = BYP ? b2 : 32'd0;
        return t;
    endfunction

    // Bank-write log captured on every committing edge.
    logic [36:0] wlog[$];
    bit          log_en = 1'b0;
    always @(posedge clk) begin
        if (log_en && rf_write) wlog.push_back({rf_wr, rf_writereg});
    end

    vec_t vecs[22];

    initial begin
        logic [36:0] exp_w [12];
        bit          drained;

        vecs[0]  = mk(1,1,9,99,   0,0,0, 0,1,0,0,0,      0,0,0,0);
        vecs[1]  = mk(0,0,0,0,    0,0,0, 0,1,0,0,0,      0,0,0,0);
        vecs[2]  = mk(0,1,3,'h1E, 0,0,0, 0,1,0,0,0,      0,0,0,0);
        vecs[3]  = mk(0,0,0,0,    0,0,0, 1,1,1,3,'h1E,   0,0,0,0);
        vecs[4]  = mk(0,0,0,0,    0,0,0, 0,1,0,0,0,      0,0,0,0);
        vecs[5]  = mk(0,1,1,10,   1,0,0, 0,1,0,0,0,      0,0,0,0);
        vecs[6]  = mk(0,1,2,20,   1,0,0, 1,1,0,1,10,     0,0,0,0);
        vecs[7]  = mk(0,1,3,30,   1,0,0, 2,1,0,1,10,     0,0,0,0);
        vecs[8]  = mk(0,1,4,40,   1,0,0, 3,1,0,1,10,     0,0,0,0);
        vecs[9]  = mk(0,1,5,50,   1,0,0, 4,0,0,1,10,     0,0,0,0);
        vecs[10] = mk(0,1,5,50,   0,0,0, 4,0,1,1,10,     0,0,0,0);
        vecs[11] = mk(0,0,0,0,    0,0,0, 3,1,1,2,20,     0,0,0,0);
        vecs[12] = mk(0,0,0,0,    0,0,0, 2,1,1,3,30,     0,0,0,0);
        vecs[13] = mk(0,0,0,0,    0,0,0, 1,1,1,4,40,     0,0,0,0);
        vecs[14] = mk(0,0,0,0,    0,0,0, 0,1,0,0,0,      0,0,0,0);
        vecs[15] = mk(0,1,5,'h50, 1,5,6, 0,1,0,0,0,      0,0,0,0);
        vecs[16] = mk(0,1,7,'h70, 1,5,6, 1,1,0,5,'h50,   1,'h50,0,0);
        vecs[17] = mk(0,1,5,'h55, 1,5,6, 2,1,0,5,'h50,   1,'h50,0,0);
        vecs[18] = mk(0,0,0,0,    1,5,6, 3,1,0,5,'h50,   1,'h55,0,0);
        vecs[19] = mk(0,0,0,0,    1,7,5, 3,1,0,5,'h50,   1,'h70,1,'h55);
        vecs[20] = mk(1,0,0,0,    1,0,1, 3,1,0,5,'h50,   0,0,0,0);
        vecs[21] = mk(0,0,0,0,    0,0,1, 0,1,0,0,0,      0,0,0,0);

        reset = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0;
        drain_hold = 1'b0; sr1 = '0; sr2 = '0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            reset = vecs[i].rst; in_valid = vecs[i].v; in_dest = vecs[i].d;
            in_data = vecs[i].dat; drain_hold = vecs[i].hold;
            sr1 = vecs[i].s1; sr2 = vecs[i].s2;
            #1;
            checks++;
            if (int'(level) == vecs[i].lvl && in_ready == vecs[i].rdy && rf_write == vecs[i].wr &&
                rf_wr == vecs[i].ewr && rf_writereg == vecs[i].edat && hit1 == vecs[i].h1 &&
                byp1 == vecs[i].b1 && hit2 == vecs[i].h2 && byp2 == vecs[i].b2) begin
                passed++;
            end else begin
                $display("FAIL vec%0d: got lvl=%0d rdy=%0b wr=%0b idx=%0d dat=%h h1=%0b b1=%h h2=%0b b2=%h; want lvl=%0d rdy=%0b wr=%0b idx=%0d dat=%h h1=%0b b1=%h h2=%0b b2=%h",
                         i, level, in_ready, rf_write, rf_wr, rf_writereg, hit1, byp1, hit2, byp2,
                         vecs[i].lvl, vecs[i].rdy, vecs[i].wr, vecs[i].ewr, vecs[i].edat,
                         vecs[i].h1, vecs[i].b1, vecs[i].h2, vecs[i].b2);
            end
        end

        // Steady-state push+pop at level 2 across several pointer wraps; first entry targets index 0.
        @(negedge clk);
        reset = 1'b0; drain_hold = 1'b1; in_valid = 1'b1; in_dest = 5'd0; in_data = 32'hA0;
        @(negedge clk);
        in_dest = 5'd1; in_data = 32'hA1;
        exp_w[0] = {5'd0, 32'hA0};
        exp_w[1] = {5'd1, 32'hA1};
        wlog.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            log_en = 1'b1; drain_hold = 1'b0; in_valid = 1'b1;
            in_dest = 5'(i + 2); in_data = 32'hB0 + 32'(i);
            exp_w[i + 2] = {5'(i + 2), 32'hB0 + 32'(i)};
            #1;
            checks++;
            if (int'(level) == 2) passed++;
            else $display("FAIL stream_level cycle %0d: got %0d want 2", i, level);
        end
        @(negedge clk);
        in_valid = 1'b0;
        drained = 1'b0;
        for (int c = 0; c < 10 && !drained; c++) begin
            #1;
            if (level == 3'd0) drained = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (drained) passed++;
        else $display("FAIL drain_timeout: level=%0d want 0 within 10 cycles", level);
        @(negedge clk);
        log_en = 1'b0;
        checks++;
        if (wlog.size() == 12) passed++;
        else $display("FAIL write_count: got %0d want 12", wlog.size());
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (i < wlog.size() && wlog[i] == exp_w[i]) passed++;
            else if (i < wlog.size())
                $display("FAIL write_order[%0d]: got idx=%0d dat=%h want idx=%0d dat=%h",
                         i, wlog[i][36:32], wlog[i][31:0], exp_w[i][36:32], exp_w[i][31:0]);
            else
                $display("FAIL write_order[%0d]: missing, want idx=%0d dat=%h",
                         i, exp_w[i][36:32], exp_w[i][31:0]);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/wb_write_queue.md
WB_WRITE_QUEUE -- requirements
Module: wb_write_queue

Interface
REQ-001 Parameter: DEPTH, default 4, number of pending write entries (power of two, 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on posedge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  producer offers a register write this cycle.
REQ-005 Port: in_dest  input  5  destination register index of the offered write.
REQ-006 Port: in_data  input  32  data of the offered write.
REQ-007 Port: in_ready  output  1  queue accepts an offer this cycle.
REQ-008 Port: drain_hold  input  1  blocks draining to the register bank this cycle.
REQ-009 Port: rf_write  output  1  write enable to the register bank.
REQ-010 Port: rf_wr  output  5  register bank write index.
REQ-011 Port: rf_writereg  output  32  register bank write data.
REQ-012 Port: sr1, sr2  input  5 each  source indices under lookup by the read stage.
REQ-013 Port: hit1, hit2  output  1 each  a pending entry targets sr1 / sr2.
REQ-014 Port: byp1, byp2  output  32 each  data of the newest pending entry for sr1 / sr2.
REQ-015 Port: level  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-016 Queue SHALL be strict FIFO of (dest, data) pairs; push when in_valid && in_ready at posedge.
REQ-017 in_ready SHALL equal (level < DEPTH), combinational from occupancy only; no push accepted when full, even with a simultaneous pop.
REQ-018 rf_write SHALL equal (level != 0) && !drain_hold; rf_wr/rf_writereg SHALL present the head entry combinationally.
REQ-019 Head SHALL be popped at each posedge where rf_write is 1 (the bank commits it on that same edge).
REQ-020 Push-to-drain latency SHALL be exactly 1 cycle: an entry pushed into an empty queue appears on rf_write the next cycle; no same-cycle pass-through.
REQ-021 Simultaneous push and pop (not full) SHALL leave level unchanged and preserve order.
REQ-022 Read/write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or underflow.
REQ-023 When level == 0, rf_wr and rf_writereg SHALL be 0.
REQ-024 Dest index 0 SHALL be queued and drained like any other index (the bank has no hardwired zero).
REQ-025 in_valid while !in_ready SHALL be ignored; no state change; producer holds the offer.
REQ-026 hitN SHALL be 1 iff any valid entry has dest == srN; bypN SHALL be the data of the youngest such entry, else 0.
REQ-027 Lookup SHALL cover only stored entries, including the head being drained this cycle, and exclude the in_* offer of the same cycle.

Reset
REQ-028 On posedge with reset = 1, level SHALL be 0 and pointers 0, and all pending entries SHALL be discarded without being written.
REQ-029 During and immediately after reset: in_ready = 1, rf_write = 0, hit1 = hit2 = 0, byp1 = byp2 = 0; reset SHALL take priority over a simultaneous push or pop.

Configuration
REQ-030 Macro WBQ_BYPASS_EN: when defined, hit1/hit2/byp1/byp2 SHALL behave per REQ-026/027.
REQ-031 When WBQ_BYPASS_EN is undefined, hit1/hit2 SHALL be tied 0, byp1/byp2 tied 0, and no lookup comparators SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-032 Reset, then push (dest 3, 0x1E) with drain_hold = 0 -> next cycle rf_write = 1, rf_wr = 3, rf_writereg = 0x1E; following cycle level = 0, rf_write = 0.
REQ-033 drain_hold = 1, push dests 1,2,3,4 with data 10,20,30,40 -> level = 4, in_ready = 0; fifth offer ignored; release hold -> bank writes 1,2,3,4 in order on four consecutive cycles.
REQ-034 Bypass (WBQ_BYPASS_EN defined), drain_hold = 1, queue holds (5,0x50),(7,0x70),(5,0x55); sr1 = 5, sr2 = 6 -> hit1 = 1, byp1 = 0x55, hit2 = 0, byp2 = 0.
REQ-035 Level 2 with drain active, push every cycle for 10 cycles -> level stays 2, output order equals input order, pointers wrap without loss.
REQ-036 Level 3 with hold, assert reset for one cycle -> level = 0, rf_write = 0, in_ready = 1, none of the three entries written to the bank.
REQ-037 Build without WBQ_BYPASS_EN, repeat REQ-034 stimulus -> hit1 = hit2 = 0, byp1 = byp2 = 0, drain order unchanged.
